hacd_mc_axi_rd_arb: RTL and testbench
=====================================

Name: hacd_mc_axi_rd_arb

Overview:
- Two-requester AXI4 read-channel arbiter in front of the single memory-controller read port (HACD_MC_AXI_RD_BUS master side).
- Grants one requester at a time, round-robin, with exactly one transaction outstanding.
- Forwards the granted AR request to memory and steers R beats back to the owner.
- Checks beat count against arlen and flags mismatches.

Parameters:
- ADDR_W, 64, AXI address width
- DATA_W, 256, AXI data width (32-byte beat)
- LEN_W, 8, arlen width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_arvalid  in  2  per-requester AR valid (index 0/1)
- s_araddr  in  2*ADDR_W  per-requester address
- s_arlen  in  2*LEN_W  per-requester burst length-1
- s_arready  out  2  per-requester AR ready
- s_rvalid  out  2  per-requester R valid
- s_rdata  out  DATA_W  shared R data, qualified by s_rvalid
- s_rresp  out  2  shared R resp
- s_rlast  out  1  shared R last
- s_rready  in  2  per-requester R ready
- m_arvalid  out  1  to memory AR valid
- m_araddr  out  ADDR_W  to memory address
- m_arlen  out  LEN_W  to memory length
- m_arready  in  1  from memory
- m_rvalid  in  1  from memory
- m_rdata  in  DATA_W  from memory
- m_rresp  in  2  from memory
- m_rlast  in  1  from memory
- m_rready  out  1  to memory
- busy  out  1  transaction in flight (state != IDLE)
- len_err  out  1  one-cycle pulse on beat-count mismatch

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. Reset forces state=IDLE, gnt=0, last_gnt=1 (so requester 0 wins first), beat_cnt=0. All outputs are 0 during reset, including m_arvalid, s_arready, s_rvalid, m_rready, busy and len_err.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_arvalid is set, pick the winner and go to ADDR next cycle.
  - Only one valid: that requester wins.
  - Both valid: the requester != last_gnt wins.
  - Latch gnt, araddr and arlen into registers; load beat_cnt=0.
  - No arready is issued in IDLE.
- ADDR:
  - m_arvalid=1; m_araddr and m_arlen come from the latched registers.
  - s_arready[gnt]=m_arready combinationally; s_arready[!gnt]=0.
  - On m_arready go to DATA.
  - Requesters hold their valid per AXI; the latched copy is authoritative.
- DATA:
  - s_rvalid[gnt]=m_rvalid; s_rvalid[!gnt]=0.
  - m_rready=s_rready[gnt]; s_rdata, s_rresp and s_rlast pass through combinationally (zero latency).
  - Each handshake (m_rvalid & m_rready) increments beat_cnt (LEN_W+1 bits, no wrap).
  - On a handshake with m_rlast: last_gnt<=gnt and go to IDLE.
  - len_err pulses when m_rlast arrives with beat_cnt != latched arlen.
  - len_err also pulses when a handshake with beat_cnt == arlen arrives without m_rlast. The state stays DATA until rlast.
- Arbitration latency: request in IDLE -> m_arvalid asserted the next cycle. At most one new grant per transaction. Back-to-back transactions have a one-cycle IDLE bubble.
- Outside DATA: m_rready=0 and any m_rvalid is ignored (no forwarding, no count).
- A requester dropping s_arvalid after grant does not cancel the transaction.
- Reset mid-transaction: asynchronous return to IDLE; in-flight beats are abandoned with no error pulse.
- Non-granted requester: never sees arready or rvalid.

Test Plan:
- Single request, port0 arvalid, addr=0x1000, arlen=3, m_arready=1 -> m_arvalid on cycle+1 with addr 0x1000 / len 3; 4 beats routed to s_rvalid[0] only; busy drops the cycle after rlast; len_err stays 0.
- Both ports request simultaneously from reset (len 0) -> port0 served first, then port1. Next simultaneous pair -> port0 (last_gnt=1), confirming alternation over 4 transactions.
- Backpressure: s_rready[1] toggles 1,0,0,1 during a 2-beat burst -> m_rready mirrors it; exactly 2 beats counted; data is unchanged while stalled.
- Early rlast: arlen=3, memory asserts rlast on beat 2 -> len_err pulses 1 cycle; FSM goes to IDLE.
- Missing rlast: arlen=1, beat 2 without rlast -> len_err pulse; rlast on beat 3 -> IDLE.
- Assert rst_n=0 mid-burst after 1 of 4 beats -> all outputs 0 immediately; after release, port0 request is granted normally.

Source files
------------

// File: rtl/hacd_mc_axi_rd_arb.sv
// Two-requester round-robin AXI4 read arbiter in front of a single memory read port.
// One transaction outstanding at a time; R beats are steered to the owner and counted against arlen.
module hacd_mc_axi_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          s_arvalid,
  input  logic [2*ADDR_W-1:0] s_araddr,
  input  logic [2*LEN_W-1:0]  s_arlen,
  output logic [1:0]          s_arready,
  output logic [1:0]          s_rvalid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  input  logic [1:0]          s_rready,
  output logic                m_arvalid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [LEN_W-1:0]    m_arlen,
  input  logic                m_arready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  output logic                m_rready,
  output logic                busy,
  output logic                len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e             state_q, state_d;
  logic               gnt_q, last_gnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W:0]     beat_cnt_q;

  logic               win;
  logic               r_hs;
  logic               len_match;
  logic [1:0]         gnt_onehot;

  // With both requesting, the one that did not own the last transaction wins.
  assign win        = (&s_arvalid) ? ~last_gnt_q : s_arvalid[1];
  assign gnt_onehot = gnt_q ? 2'b10 : 2'b01;
  assign len_match  = (beat_cnt_q == {1'b0, len_q});
  assign r_hs       = (state_q == DATA) && m_rvalid && m_rready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    m_arvalid = 1'b0;
    s_arready = 2'b00;
    s_rvalid  = 2'b00;
    m_rready  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    s_rlast   = 1'b0;
    len_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|s_arvalid) state_d = ADDR;
      end
      ADDR: begin
        m_arvalid = 1'b1;
        s_arready = m_arready ? gnt_onehot : 2'b00;
        if (m_arready) state_d = DATA;
      end
      DATA: begin
        s_rvalid = m_rvalid ? gnt_onehot : 2'b00;
        m_rready = s_rready[gnt_q];
        s_rdata  = m_rdata;
        s_rresp  = m_rresp;
        s_rlast  = m_rlast;
        // Flag an rlast on the wrong beat, and the expected final beat arriving without rlast.
        len_err  = r_hs && (m_rlast ? !len_match : len_match);
        if (r_hs && m_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_araddr = addr_q;
  assign m_arlen  = len_q;
  assign busy     = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (|s_arvalid)) begin
        gnt_q      <= win;
        addr_q     <= win ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
        len_q      <= win ? s_arlen[2*LEN_W-1:LEN_W] : s_arlen[LEN_W-1:0];
        beat_cnt_q <= '0;
      end
      if (r_hs) begin
        if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 1'b1;
        if (m_rlast) last_gnt_q <= gnt_q;
      end
    end
  end

endmodule

// File: tb/tb_hacd_mc_axi_rd_arb.sv
// Directed self-checking bench for hacd_mc_axi_rd_arb: grant order, routing, backpressure,
// beat-count errors and asynchronous reset. Inputs change on the falling edge, outputs sampled #1 later.
module tb_hacd_mc_axi_rd_arb;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 8;

  logic                clk;
  logic                rst_n;
  logic [1:0]          s_arvalid;
  logic [2*ADDR_W-1:0] s_araddr;
  logic [2*LEN_W-1:0]  s_arlen;
  logic [1:0]          s_arready;
  logic [1:0]          s_rvalid;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rlast;
  logic [1:0]          s_rready;
  logic                m_arvalid;
  logic [ADDR_W-1:0]   m_araddr;
  logic [LEN_W-1:0]    m_arlen;
  logic                m_arready;
  logic                m_rvalid;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rlast;
  logic                m_rready;
  logic                busy;
  logic                len_err;

  int n_checks = 0;
  int n_fail   = 0;

  hacd_mc_axi_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_arvalid (s_arvalid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arready (s_arready),
    .s_rvalid  (s_rvalid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rready  (s_rready),
    .m_arvalid (m_arvalid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arready (m_arready),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rready  (m_rready),
    .busy      (busy),
    .len_err   (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".s_arready"}, 256'(s_arready), 256'(0));
    check({tag, ".s_rvalid"},  256'(s_rvalid),  256'(0));
    check({tag, ".s_rdata"},   256'(s_rdata),   256'(0));
    check({tag, ".m_arvalid"}, 256'(m_arvalid), 256'(0));
    check({tag, ".m_rready"},  256'(m_rready),  256'(0));
    check({tag, ".busy"},      256'(busy),      256'(0));
    check({tag, ".len_err"},   256'(len_err),   256'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    s_arvalid = 2'b11;
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_rdata   = {8{32'hdead_beef}};
    m_rlast   = 1'b1;
    s_rready  = 2'b11;
    #1 check_all_zero("reset");
    @(negedge clk);
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    rst_n     = 1'b1;
  endtask

  // One IDLE cycle (request presented) then the ADDR cycle with m_arready high.
  task automatic issue(input logic [1:0] vld, input logic [63:0] a0, input logic [63:0] a1,
                       input logic [7:0] l0, input logic [7:0] l1, input logic g);
    logic [63:0] ea;
    logic [7:0]  el;
    ea = g ? a1 : a0;
    el = g ? l1 : l0;
    @(negedge clk);
    s_arvalid = vld;
    s_araddr  = {a1, a0};
    s_arlen   = {l1, l0};
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    s_rready  = 2'b11;
    #1;
    check("idle.busy",      256'(busy),      256'(0));
    check("idle.m_arvalid", 256'(m_arvalid), 256'(0));
    check("idle.s_arready", 256'(s_arready), 256'(0));
    check("idle.m_rready",  256'(m_rready),  256'(0));
    @(negedge clk);
    // Requester withdraws and scribbles its address: the latched copy must be what goes out.
    s_arvalid = 2'b00;
    s_araddr  = '1;
    s_arlen   = '1;
    m_arready = 1'b1;
    #1;
    check("addr.m_arvalid", 256'(m_arvalid), 256'(1));
    check("addr.m_araddr",  256'(m_araddr),  256'(ea));
    check("addr.m_arlen",   256'(m_arlen),   256'(el));
    check("addr.s_arready", 256'(s_arready), 256'(g ? 2'b10 : 2'b01));
    check("addr.busy",      256'(busy),      256'(1));
    check("addr.s_rvalid",  256'(s_rvalid),  256'(0));
    check("addr.m_rready",  256'(m_rready),  256'(0));
  endtask

  task automatic beat(input logic [255:0] d, input logic last, input logic [1:0] rdy,
                      input logic g, input logic exp_err);
    @(negedge clk);
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = d;
    m_rresp   = d[1:0];
    m_rlast   = last;
    s_rready  = rdy;
    #1;
    check("data.s_rvalid", 256'(s_rvalid), 256'(g ? 2'b10 : 2'b01));
    check("data.s_rdata",  s_rdata,        d);
    check("data.s_rresp",  256'(s_rresp),  256'(d[1:0]));
    check("data.s_rlast",  256'(s_rlast),  256'(last));
    check("data.m_rready", 256'(m_rready), 256'(rdy[g]));
    check("data.len_err",  256'(len_err),  256'(exp_err));
    check("data.busy",     256'(busy),     256'(1));
  endtask

  initial begin
    rst_n     = 1'b1;
    s_arvalid = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_rready  = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;

    do_reset();

    // Single 4-beat burst on port 0.
    issue(2'b01, 64'h1000, 64'h0, 8'd3, 8'd0, 1'b0);
    beat(256'h11, 1'b0, 2'b01, 1'b0, 1'b0);
    beat(256'h22, 1'b0, 2'b01, 1'b0, 1'b0);
    beat(256'h33, 1'b0, 2'b01, 1'b0, 1'b0);
    beat(256'h44, 1'b1, 2'b01, 1'b0, 1'b0);

    // Alternation from reset: 0, 1, 0, 1.
    do_reset();
    issue(2'b11, 64'hA000, 64'hB000, 8'd0, 8'd0, 1'b0);
    beat(256'h50, 1'b1, 2'b11, 1'b0, 1'b0);
    issue(2'b11, 64'hA040, 64'hB040, 8'd0, 8'd0, 1'b1);
    beat(256'h61, 1'b1, 2'b11, 1'b1, 1'b0);
    issue(2'b11, 64'hA080, 64'hB080, 8'd0, 8'd0, 1'b0);
    beat(256'h72, 1'b1, 2'b11, 1'b0, 1'b0);
    issue(2'b11, 64'hA0C0, 64'hB0C0, 8'd0, 8'd0, 1'b1);
    beat(256'h83, 1'b1, 2'b11, 1'b1, 1'b0);

    // Backpressure on port 1: ready 1,0,0,1 over a 2-beat burst.
    issue(2'b10, 64'h0, 64'h2000, 8'd0, 8'd1, 1'b1);
    beat(256'h900, 1'b0, 2'b10, 1'b1, 1'b0);
    beat(256'h901, 1'b0, 2'b00, 1'b1, 1'b0);
    beat(256'h901, 1'b0, 2'b00, 1'b1, 1'b0);
    beat(256'h901, 1'b1, 2'b10, 1'b1, 1'b0);

    // Early rlast: arlen=3, rlast on the second beat.
    issue(2'b01, 64'h3000, 64'h0, 8'd3, 8'd0, 1'b0);
    beat(256'hA0, 1'b0, 2'b01, 1'b0, 1'b0);
    beat(256'hA1, 1'b1, 2'b01, 1'b0, 1'b1);

    // Missing rlast: arlen=1, second beat lacks rlast, third beat carries it (count 2 != 1).
    issue(2'b10, 64'h0, 64'h4000, 8'd0, 8'd1, 1'b1);
    beat(256'hB0, 1'b0, 2'b10, 1'b1, 1'b0);
    beat(256'hB1, 1'b0, 2'b10, 1'b1, 1'b1);
    beat(256'hB2, 1'b1, 2'b10, 1'b1, 1'b1);
    @(negedge clk);
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1 check("post_missing.busy", 256'(busy), 256'(0));

    // Reset after 1 of 4 beats, then a normal grant on port 0.
    issue(2'b01, 64'h5000, 64'h0, 8'd3, 8'd0, 1'b0);
    beat(256'hC0, 1'b0, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    m_rvalid = 1'b1;
    m_rdata  = 256'hC1;
    s_rready = 2'b01;
    rst_n    = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst_n    = 1'b1;
    m_rvalid = 1'b0;
    issue(2'b01, 64'h6000, 64'h0, 8'd0, 8'd0, 1'b0);
    beat(256'hD0, 1'b1, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1 check("final.busy", 256'(busy), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
